// File: rtl/data_mem_mmio.sv
// Word-organised data RAM for the CPU memory-access stage, with an optional MMIO window
// (GPIO, cycle counter, compare timer) compiled in when DMEM_MMIO_EN is defined.
module data_mem_mmio #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [15:0] MMIO_BASE   = 16'hFF00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        halt,
    input  logic        read_wrn,
    input  logic [15:0] address,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic [7:0]  gpio_out,
    output logic        timer_irq
);

    localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [16:0] RAM_BYTES = 17'(4 * DEPTH_WORDS);

    logic [31:0]   ram_q [DEPTH_WORDS];
    logic [AW-1:0] ram_idx;
    logic          ram_hit;
    logic          wr_en;
    logic          mmio_hit;
    logic [31:0]   mmio_rdata;
    logic          unused_bits;

    assign ram_idx     = address[2 +: AW];
    assign ram_hit     = {1'b0, address} < RAM_BYTES;
    assign wr_en       = !read_wrn && !halt && !rst;
    assign unused_bits = ^{address[1:0], MMIO_BASE};

    // RAM has no reset: contents survive rst, and a write is dropped while rst is high
    always_ff @(posedge clk) begin
        if (wr_en && ram_hit) begin
            ram_q[ram_idx] <= data_in;
        end
    end

`ifdef DMEM_MMIO_EN
    logic [7:0]  gpio_q, gpio_d;
    logic [31:0] cyc_q, cyc_d;
    logic [31:0] cmp_q, cmp_d;
    logic        en_q, en_d;
    logic        pend_q, pend_d;
    logic        mmio_wr;

    // RAM wins if a large DEPTH_WORDS ever overlaps the window
    assign mmio_hit = (address[15:4] == MMIO_BASE[15:4]) && !ram_hit;
    assign mmio_wr  = wr_en && mmio_hit;

    always_comb begin
        gpio_d = gpio_q;
        cyc_d  = cyc_q;
        cmp_d  = cmp_q;
        en_d   = en_q;
        pend_d = pend_q;
        if (!halt) begin
            cyc_d = cyc_q + 32'd1;
            if (mmio_wr) begin
                case (address[3:2])
                    2'd0: gpio_d = data_in[7:0];
                    2'd2: cmp_d  = data_in;
                    2'd3: begin
                        en_d = data_in[0];
                        if (data_in[1]) pend_d = 1'b0;
                    end
                    default: ;
                endcase
            end
            // Compare uses pre-write EN/CMP and pre-increment count; set beats W1C
            if (en_q && (cyc_q == cmp_q)) pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gpio_q <= 8'h00;
            cyc_q  <= 32'h0000_0000;
            cmp_q  <= 32'hFFFF_FFFF;
            en_q   <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            gpio_q <= gpio_d;
            cyc_q  <= cyc_d;
            cmp_q  <= cmp_d;
            en_q   <= en_d;
            pend_q <= pend_d;
        end
    end

    always_comb begin
        case (address[3:2])
            2'd0:    mmio_rdata = {24'h0, gpio_q};
            2'd1:    mmio_rdata = cyc_q;
            2'd2:    mmio_rdata = cmp_q;
            default: mmio_rdata = {30'h0, pend_q, en_q};
        endcase
    end

    assign gpio_out  = gpio_q;
    assign timer_irq = en_q & pend_q;
`else
    assign mmio_hit   = 1'b0;
    assign mmio_rdata = 32'h0;
    assign gpio_out   = 8'h00;
    assign timer_irq  = 1'b0;
`endif

    always_comb begin
        data_out = 32'h0;
        if (!rst && read_wrn) begin
            if (ram_hit) begin
                data_out = ram_q[ram_idx];
            end else if (mmio_hit) begin
                data_out = mmio_rdata;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_mmio.sv
// Scoreboard bench for data_mem_mmio: a driver pushes expected outputs from a behavioural
// model into a queue, and a negedge monitor pops and compares them against the DUT.
module tb_data_mem_mmio;

    localparam int          DEPTH = 1024;
    localparam logic [15:0] BASE  = 16'hFF00;
`ifdef DMEM_MMIO_EN
    localparam bit MMIO_ON = 1'b1;
`else
    localparam bit MMIO_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        halt;
    logic        read_wrn;
    logic [15:0] address;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic [7:0]  gpio_out;
    logic        timer_irq;

    data_mem_mmio #(.DEPTH_WORDS(DEPTH), .MMIO_BASE(BASE)) dut (
        .clk(clk), .rst(rst), .halt(halt), .read_wrn(read_wrn), .address(address),
        .data_in(data_in), .data_out(data_out), .gpio_out(gpio_out), .timer_irq(timer_irq)
    );

    always #5 clk = ~clk;

    int tb_cyc = 0;
    always @(posedge clk) tb_cyc <= tb_cyc + 1;

    typedef struct {
        int          cyc;
        int          kind;   // 0 data_out, 1 gpio_out, 2 timer_irq
        logic [31:0] val;
        bit          ne;     // 1: value must differ from val
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state
    logic [31:0] m_mem [int];
    logic [7:0]  m_gpio;
    logic [31:0] m_cyc, m_cmp;
    bit          m_en, m_pend;

    function automatic void m_reset();
        m_gpio = 8'h00; m_cyc = 32'h0; m_cmp = 32'hFFFF_FFFF; m_en = 1'b0; m_pend = 1'b0;
    endfunction

    function automatic bit is_ram(input logic [15:0] a);
        return int'(a) < 4 * DEPTH;
    endfunction

    function automatic bit is_mmio(input logic [15:0] a);
        return MMIO_ON && !is_ram(a) && ((a & 16'hFFF0) == BASE);
    endfunction

    task automatic m_read(input logic [15:0] a, output logic [31:0] v, output bit known);
        int key;
        key = int'(a) / 4;
        known = 1'b1;
        v = 32'h0;
        if (is_ram(a)) begin
            if (m_mem.exists(key)) v = m_mem[key];
            else known = 1'b0;
        end else if (is_mmio(a)) begin
            case ((int'(a) / 4) % 4)
                0: v = {24'h0, m_gpio};
                1: v = m_cyc;
                2: v = m_cmp;
                default: v = {30'h0, m_pend, m_en};
            endcase
        end
    endtask

    function automatic void m_commit(input logic rw, input logic [15:0] a, input logic [31:0] d,
                                     input logic h);
        bit match;
        if (h) return;
        match = m_en && (m_cyc == m_cmp);
        m_cyc = m_cyc + 32'd1;
        if (!rw) begin
            if (is_ram(a)) m_mem[int'(a) / 4] = d;
            else if (is_mmio(a)) begin
                case ((int'(a) / 4) % 4)
                    0: m_gpio = d[7:0];
                    2: m_cmp = d;
                    3: begin
                        m_en = d[0];
                        if (d[1]) m_pend = 1'b0;
                    end
                    default: ;
                endcase
            end
        end
        if (match) m_pend = 1'b1;
    endfunction

    task automatic push(input int kind, input logic [31:0] val, input bit ne, input string nm);
        exp_t e;
        e.cyc = tb_cyc; e.kind = kind; e.val = val; e.ne = ne; e.name = nm;
        sb.push_back(e);
    endtask

    // Called just after a rising edge: applies inputs for one cycle and queues expectations
    task automatic drive(input logic rw, input logic [15:0] a, input logic [31:0] d,
                         input logic h, input string nm);
        logic [31:0] v;
        bit          known;
        read_wrn = rw; address = a; data_in = d; halt = h;
        if (!rw) push(0, 32'h0, 1'b0, {nm, "_dout_wr"});
        else begin
            m_read(a, v, known);
            if (known) push(0, v, 1'b0, nm);
        end
        push(1, MMIO_ON ? {24'h0, m_gpio} : 32'h0, 1'b0, {nm, "_gpio"});
        push(2, (MMIO_ON && m_en && m_pend) ? 32'h1 : 32'h0, 1'b0, {nm, "_irq"});
        @(posedge clk);
        m_commit(rw, a, d, h);
        #1;
    endtask

    task automatic drive_ne(input logic [15:0] a, input logic [31:0] notv, input string nm);
        push(0, notv, 1'b1, nm);
        drive(1'b1, a, 32'h0, 1'b0, nm);
    endtask

    task automatic reset_pulse();
        rst = 1'b1; halt = 1'b0; read_wrn = 1'b0; address = 16'h0030; data_in = 32'hBAD0_BAD0;
        m_reset();
        push(0, 32'h0, 1'b0, "rst_dout");
        push(1, 32'h0, 1'b0, "rst_gpio");
        push(2, 32'h0, 1'b0, "rst_irq");
        @(posedge clk);
        #1;
        rst = 1'b0; read_wrn = 1'b1;
    endtask

    always @(negedge clk) begin : monitor
        exp_t        e;
        logic [31:0] act;
        while (sb.size() > 0 && sb[0].cyc <= tb_cyc) begin
            e = sb.pop_front();
            case (e.kind)
                0:       act = data_out;
                1:       act = {24'h0, gpio_out};
                default: act = {31'h0, timer_irq};
            endcase
            n_checks++;
            if (e.cyc != tb_cyc) begin
                n_fail++;
                $display("FAIL %s: expectation for cycle %0d not checked in time (now %0d)",
                         e.name, e.cyc, tb_cyc);
            end else if (e.ne ? (act === e.val) : (act !== e.val)) begin
                n_fail++;
                $display("FAIL %s: got %h, required %s%h", e.name, act, e.ne ? "not " : "", e.val);
            end
        end
    end

    initial begin
        logic [15:0] a;
        logic [31:0] d;
        int          sel;
        int          w;
        rst = 1'b1; halt = 1'b0; read_wrn = 1'b1; address = 16'h0; data_in = 32'h0;
        m_reset();
        @(posedge clk);
        #1;
        reset_pulse();

        // RAM write/read, ignored low address bits, neighbouring word
        drive(1'b0, 16'h0010, 32'hDEAD_BEEF, 1'b0, "w10");
        drive(1'b1, 16'h0010, 32'h0, 1'b0, "ram_rd_10");
        drive(1'b1, 16'h0013, 32'h0, 1'b0, "ram_rd_13");
        drive_ne(16'h0014, 32'hDEAD_BEEF, "ram_rd_14_ne");

        // Unmapped access and halted write
        drive(1'b0, 16'h8000, 32'h1234_5678, 1'b0, "w8000");
        drive(1'b1, 16'h8000, 32'h0, 1'b0, "unmapped_rd");
        drive(1'b0, 16'h0020, 32'h1111_1111, 1'b0, "w20");
        drive(1'b0, 16'h0020, 32'hA5A5_A5A5, 1'b1, "w20_halt");
        drive(1'b1, 16'h0020, 32'h0, 1'b0, "halt_wr_dropped");

        // GPIO, then reset with a pending write that must be lost
        drive(1'b0, 16'h0030, 32'h0C0F_FEE0, 1'b0, "w30");
        drive(1'b0, 16'hFF00, 32'h0000_01C3, 1'b0, "gpio_wr");
        drive(1'b1, 16'hFF00, 32'h0, 1'b0, "gpio_rd");
        reset_pulse();
        drive(1'b1, 16'h0030, 32'h0, 1'b0, "ram_kept_after_rst");

        // Counter: 10 running edges, 5 halted, write ignored
        for (int i = 0; i < 9; i++) drive(1'b1, 16'h0010, 32'h0, 1'b0, "cnt_run");
        drive(1'b1, 16'hFF04, 32'h0, 1'b0, "cnt_10");
        for (int i = 0; i < 5; i++) drive(1'b1, 16'hFF04, 32'h0, 1'b1, "cnt_halt");
        drive(1'b1, 16'hFF04, 32'h0, 1'b0, "cnt_frozen");
        drive(1'b0, 16'hFF04, 32'h0000_FFFF, 1'b0, "cnt_wr");
        drive(1'b1, 16'hFF04, 32'h0, 1'b0, "cnt_wr_ignored");

        // Timer: CMP=20, EN=1, run through the match, then W1C
        drive(1'b0, 16'hFF08, 32'd20, 1'b0, "cmp_wr");
        drive(1'b0, 16'hFF0C, 32'h1, 1'b0, "ctrl_en");
        for (int i = 0; i < 10; i++) drive(1'b1, 16'hFF0C, 32'h0, 1'b0, "tmr_run");
        drive(1'b0, 16'hFF0C, 32'h3, 1'b0, "ctrl_w1c");
        drive(1'b1, 16'hFF0C, 32'h0, 1'b0, "ctrl_after_w1c");
        // W1C landing on the matching edge must leave PEND set
        drive(1'b0, 16'hFF08, m_cyc + 32'd2, 1'b0, "cmp_wr2");
        drive(1'b1, 16'hFF08, 32'h0, 1'b0, "cmp_rd2");
        drive(1'b0, 16'hFF0C, 32'h3, 1'b0, "w1c_on_match");
        drive(1'b1, 16'hFF0C, 32'h0, 1'b0, "pend_kept");
        drive(1'b0, 16'hFF0C, 32'h2, 1'b0, "w1c_clear");
        drive(1'b0, 16'hFF00, 32'h0000_00FF, 1'b0, "gpio_ff");
        drive(1'b1, 16'hFF00, 32'h0, 1'b0, "gpio_ff_rd");

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) reset_pulse();
            sel = $urandom_range(0, 9);
            if (sel < 5)      a = 16'($urandom_range(0, 255));
            else if (sel < 8) a = BASE + 16'($urandom_range(0, 15));
            else if (sel < 9) a = 16'($urandom_range(16'h1000, 16'hFEFF));
            else              a = 16'h0FF0 + 16'($urandom_range(0, 15));
            d = $urandom;
            if (is_mmio(a) && a[3:2] == 2'd2) d = m_cyc + 32'($urandom_range(0, 8));
            if (is_mmio(a) && a[3:2] == 2'd3) d = 32'($urandom_range(0, 3));
            drive(1'($urandom_range(0, 1)), a, d, ($urandom_range(0, 9) == 0), "rand");
        end

        w = 0;
        while (sb.size() > 0 && w < 5) begin
            @(negedge clk);
            w++;
        end
        #1;
        if (sb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_mmio.md
# data_mem_mmio

Data-side memory block sitting directly downstream of the CPU memory-access stage. Consumes the CPU's read/write strobe, 16-bit byte address and 32-bit store data, and returns the 32-bit load word. Provides word-organised data RAM plus an optional memory-mapped I/O window with a GPIO output register, a free-running cycle counter and a compare timer with an interrupt flag.

## Interface
- `DEPTH_WORDS`, 1024: RAM depth in 32-bit words. The RAM region is byte addresses 0 to 4*DEPTH_WORDS-1.
- `MMIO_BASE`, 16'hFF00: base byte address of the 16-byte MMIO window.
- `clk` in 1: single clock. All state changes on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `halt` in 1: CPU pipeline halt. While high, writes are blocked and the cycle counter is frozen.
- `read_wrn` in 1: 1 = read (idle), 0 = write. Driven from MEM_ACCESS_READ_WRN.
- `address` in 16: byte address from MEM_ACCESS_ADDRESS_BUS. Bits [1:0] are ignored.
- `data_in` in 32: store data from MEM_ACCESS_DATA_OUT_BUS.
- `data_out` out 32: load data to MEM_ACCESS_DATA_IN_BUS. Combinational.
- `gpio_out` out 8: GPIO output register.
- `timer_irq` out 1: timer interrupt, level.

## Operation
- Word index is address[15:2]. All accesses are full-word. Sub-word handling stays in the CPU.
- **Decode**
  - RAM hit: address < 4*DEPTH_WORDS.
  - MMIO hit: address[15:4] == MMIO_BASE[15:4].
  - Anything else is unmapped: reads return 0, writes are dropped.
- **Write**
  - Commits at the rising edge where read_wrn==0, halt==0 and rst==0.
- **Read**
  - data_out is the selected word whenever read_wrn==1.
  - data_out is 0 while read_wrn==0 and 0 while rst is high.
- **RAM**
  - Contents are not cleared by reset.
  - Reads of never-written locations are undefined (X in simulation).
- **MMIO registers** (offset from MMIO_BASE):
  - 0x0 GPIO_OUT: RW. Bits [7:0] drive gpio_out. Bits [31:8] read 0.
  - 0x4 CYCLE_COUNT: RO. 32-bit; increments each edge with halt==0; wraps 0xFFFF_FFFF to 0. Writes are ignored.
  - 0x8 TIMER_CMP: RW, 32-bit.
  - 0xC TIMER_CTRL:
    - Bit0 EN: RW.
    - Bit1 PEND: writing 1 clears it; writing 0 has no effect.
    - Other bits read 0.
- **Timer**
  - At each edge with EN==1 and halt==0, if CYCLE_COUNT (pre-increment value) == TIMER_CMP (pre-write value), PEND is set.
  - Set has priority over a simultaneous W1C of PEND.
  - timer_irq = EN & PEND.
- **Reset values**: gpio_out=0, timer_irq=0, data_out=0, CYCLE_COUNT=0, TIMER_CMP=0xFFFF_FFFF, EN=0, PEND=0.

## Timing
- Read latency is zero. data_out is valid in the same cycle as address, so the CPU samples it at the next edge.
- Writes become visible on data_out from the cycle after the commit edge.
- A read of an address in the same cycle it is being written returns the old data. This cannot occur through the CPU, because read_wrn==0 forces data_out=0.
- Register updates after a commit edge:
  - gpio_out updates in the cycle after the commit edge.
  - timer_irq rises in the cycle after the matching edge.
  - timer_irq falls in the cycle after a PEND clear or an EN=0 write.
- When halt is asserted, all registers hold and in-flight write strobes are discarded. Reads remain live.
- Reset asserted mid-operation:
  - All registers return immediately to their reset values, asynchronously.
  - Any write pending at that edge is lost.
  - RAM contents are retained.
- On release of rst, counting starts at the first edge where rst is low.

## Configuration
- Macro `DMEM_MMIO_EN`.
- When defined: the MMIO window, GPIO register, counter and timer are compiled in, as described above.
- When undefined:
  - No MMIO logic is present.
  - The MMIO_BASE window decodes as unmapped: reads return 0, writes are dropped.
  - gpio_out and timer_irq are tied to 0.
  - RAM behaviour is unchanged.

## Test plan
- RAM write/read: write 0xDEADBEEF to 0x0010, then read 0x0010 and 0x0013 -> both return 0xDEADBEEF; reading 0x0014 does not return 0xDEADBEEF.
- Unmapped access and halt: write 0x12345678 to 0x8000, then read -> 0. Write 0xA5A5A5A5 to 0x0020 with halt=1 -> the RAM word is unchanged.
- GPIO: write 0x0000_01C3 to 0xFF00 -> gpio_out=0xC3 the next cycle, and a read returns 0x0000_00C3. Assert rst -> gpio_out=0 immediately.
- Counter: release reset, run 10 edges with halt low, then read 0xFF04 -> 10. Hold halt for 5 edges -> still 10. Write to 0xFF04 -> ignored.
- Timer: write CMP=20, CTRL=1 -> timer_irq rises the cycle after the edge where the counter equals 20. Write CTRL=0x3 -> irq clears and EN stays 1. A W1C on the matching edge leaves PEND=1.
- Without `DMEM_MMIO_EN`: write 0xFF to 0xFF00, then read -> 0; gpio_out=0 and timer_irq=0 throughout.
